cdb_broadcast_unit: RTL and testbench
=====================================

CDB_BROADCAST_UNIT -- requirements
Module: cdb_broadcast_unit

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset; ports `clock`, `reset`.
REQ-002 SHALL expose ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- sumsub_valid  input  1  sum/sub ULA result valid
- sumsub_ready  output  1  sum/sub result accepted this edge when valid
- sumsub_dest  input  3  one-hot destination {R0,R1,R2}; 000 = no register write
- sumsub_position  input  2  RS entry index
- sumsub_data  input  10  result
- ldsd_valid, ldsd_ready, ldsd_dest, ldsd_position, ldsd_data  same widths and meanings, for the load/store ULA
- cdb  output  16  broadcast word
- cdb_valid  output  1  cdb holds a broadcast this cycle
REQ-003 SHALL define the cdb layout as: [15] R0_in, [14] R1_in, [13] R2_in, [12:11] position, [10] source (1 = sum/sub ULA, 0 = load/store ULA), [9:0] data.

Function
REQ-004 SHALL buffer each source in its own 2-entry FIFO holding {dest, position, data}.
REQ-005 SHALL drive src_ready = (FIFO count < 2), combinationally from registered count.
REQ-006 SHALL push on a rising edge when src_valid && src_ready.
REQ-007 SHALL ignore src_valid when src_ready = 0; the upstream unit holds its data.
REQ-008 SHALL select at most one FIFO head per cycle. Arbitration rules:
- Only one FIFO non-empty: grant that FIFO.
- Both non-empty: round-robin, granting the source not granted on the last broadcast.
REQ-009 SHALL pop the granted head and register it into cdb/cdb_valid on the same edge.
REQ-010 Latency: an entry pushed at edge k, if granted at edge k+1, SHALL be visible on cdb after edge k+1. There is no bypass.
REQ-011 SHALL drive cdb = 16'h0000 and cdb_valid = 0 in any cycle without a grant, so that no register write bits are set.
REQ-012 SHALL allow push and pop of the same FIFO on one edge when count = 1; count stays 1 and order is preserved.
REQ-013 At count = 2, SHALL refuse the push (ready = 0) even if a pop occurs on the same edge.
REQ-014 SHALL broadcast dest = 000 entries (stores) with cdb_valid = 1, so the RS entry is freed.
REQ-015 SHALL pass dest through unchanged; a one-hot dest is the sender's obligation.
REQ-016 SHALL implement FIFO pointers as 1-bit wrap-around read/write indices plus a 2-bit count.
REQ-017 SHALL never drop, reorder (within a source) or duplicate an accepted entry.

Reset
REQ-018 While reset = 1, SHALL hold cdb = 0 and cdb_valid = 0, empty both FIFOs, and set both readies to 1.
REQ-019 SHALL reset the round-robin pointer so sum/sub wins the first tie.
REQ-020 On reset asserted mid-operation, SHALL discard buffered entries immediately and asynchronously, with no broadcast after release until a new push.

Structure
REQ-021 SHALL place the shared constants in package `cdb_pkg`:
- CDB field bit positions
- source IDs SRC_SUMSUB = 1, SRC_LDSD = 0
- FIFO depth 2
- entry field widths
REQ-022 SHALL instantiate sub-module `cdb_source_fifo` (2-entry, valid/ready in, head/empty/pop out) once per source, with arbitration and the output register in the top.

Verification
REQ-023 Reset release -> cdb = 16'h0000, cdb_valid = 0, sumsub_ready = ldsd_ready = 1.
REQ-024 Single sum/sub push at edge k with dest = 010, position = 2, data = 10'h155 -> after edge k+1: cdb = 16'h5555, cdb_valid = 1; next cycle cdb = 0.
REQ-025 Both sources push at the same edge after reset -> the sum/sub word is broadcast first (bit10 = 1), the load/store word next cycle (bit10 = 0).
REQ-026 Load/store push with dest = 000, position = 1, data = 10'h3FF -> cdb = 16'h0BFF, cdb_valid = 1.
REQ-027 Both sources valid every cycle for 10 cycles with incrementing data -> strict alternation once both FIFOs are non-empty, per-source order preserved, each ready drops at count = 2, no loss or duplication.
REQ-028 Reset asserted with both FIFOs full -> cdb = 0 and cdb_valid = 0 without waiting for a clock edge; no stale entries broadcast after release.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants, entry type and word-packing helper for the common data bus
// broadcast unit and its per-source FIFOs.
package cdb_pkg;

    localparam int CDB_W      = 16;
    localparam int DEST_W     = 3;
    localparam int POS_W      = 2;
    localparam int DATA_W     = 10;
    localparam int FIFO_DEPTH = 2;

    localparam int CDB_R0_BIT  = 15;
    localparam int CDB_R1_BIT  = 14;
    localparam int CDB_R2_BIT  = 13;
    localparam int CDB_POS_HI  = 12;
    localparam int CDB_POS_LO  = 11;
    localparam int CDB_SRC_BIT = 10;
    localparam int CDB_DATA_HI = 9;
    localparam int CDB_DATA_LO = 0;

    localparam logic SRC_SUMSUB = 1'b1;
    localparam logic SRC_LDSD   = 1'b0;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [POS_W-1:0]  position;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    // dest is {R0,R1,R2}, so dest[2] lands on the R0 write-enable bit
    function automatic logic [CDB_W-1:0] pack_cdb(input cdb_entry_t e, input logic src);
        logic [CDB_W-1:0] w;
        w = '0;
        w[CDB_R0_BIT]                = e.dest[2];
        w[CDB_R1_BIT]                = e.dest[1];
        w[CDB_R2_BIT]                = e.dest[0];
        w[CDB_POS_HI:CDB_POS_LO]     = e.position;
        w[CDB_SRC_BIT]               = src;
        w[CDB_DATA_HI:CDB_DATA_LO]   = e.data;
        return w;
    endfunction

endpackage

// File: rtl/cdb_source_fifo.sv
// Two-entry FIFO buffering one execution unit's results ahead of the CDB.
// Ready depends only on the registered count, so a full FIFO refuses even when popping.
module cdb_source_fifo
    import cdb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  cdb_entry_t in_entry,
    input  logic       pop,
    output cdb_entry_t head,
    output logic       empty
);

    logic       rd_idx_q, rd_idx_d;
    logic       wr_idx_q, wr_idx_d;
    logic [1:0] count_q, count_d;
    cdb_entry_t slot_q [FIFO_DEPTH];
    cdb_entry_t slot_d [FIFO_DEPTH];
    logic       push;
    logic       do_pop;

    assign in_ready = (count_q < 2'(FIFO_DEPTH));
    assign empty    = (count_q == 2'd0);
    assign head     = slot_q[rd_idx_q];
    assign push     = in_valid && in_ready;
    assign do_pop   = pop && !empty;

    always_comb begin
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        count_d  = count_q;
        if (push) begin
            wr_idx_d = ~wr_idx_q;
        end
        if (do_pop) begin
            rd_idx_d = ~rd_idx_q;
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx_q <= 1'b0;
            wr_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (push && (wr_idx_q == 1'(gi))) begin
                    slot_d[gi] = in_entry;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cdb_broadcast_unit.sv
// Merges sum/sub and load/store results onto a single registered CDB word,
// one broadcast per cycle, round-robin between the two source FIFOs.
module cdb_broadcast_unit
    import cdb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              sumsub_valid,
    output logic              sumsub_ready,
    input  logic [DEST_W-1:0] sumsub_dest,
    input  logic [POS_W-1:0]  sumsub_position,
    input  logic [DATA_W-1:0] sumsub_data,
    input  logic              ldsd_valid,
    output logic              ldsd_ready,
    input  logic [DEST_W-1:0] ldsd_dest,
    input  logic [POS_W-1:0]  ldsd_position,
    input  logic [DATA_W-1:0] ldsd_data,
    output logic [CDB_W-1:0]  cdb,
    output logic              cdb_valid
);

    cdb_entry_t       sumsub_entry, ldsd_entry;
    cdb_entry_t       sumsub_head, ldsd_head;
    logic             sumsub_empty, ldsd_empty;
    logic             grant_sumsub, grant_ldsd;
    logic             last_src_q, last_src_d;
    logic [CDB_W-1:0] cdb_q, cdb_d;
    logic             cdb_valid_q, cdb_valid_d;

    assign sumsub_entry = '{dest: sumsub_dest, position: sumsub_position, data: sumsub_data};
    assign ldsd_entry   = '{dest: ldsd_dest, position: ldsd_position, data: ldsd_data};

    cdb_source_fifo u_sumsub_fifo (
        .clock    (clock),
        .reset    (reset),
        .in_valid (sumsub_valid),
        .in_ready (sumsub_ready),
        .in_entry (sumsub_entry),
        .pop      (grant_sumsub),
        .head     (sumsub_head),
        .empty    (sumsub_empty)
    );

    cdb_source_fifo u_ldsd_fifo (
        .clock    (clock),
        .reset    (reset),
        .in_valid (ldsd_valid),
        .in_ready (ldsd_ready),
        .in_entry (ldsd_entry),
        .pop      (grant_ldsd),
        .head     (ldsd_head),
        .empty    (ldsd_empty)
    );

    // On a tie the source that did not win the previous broadcast goes next
    always_comb begin
        grant_sumsub = 1'b0;
        grant_ldsd   = 1'b0;
        last_src_d   = last_src_q;
        cdb_d        = '0;
        cdb_valid_d  = 1'b0;
        if (!sumsub_empty && !ldsd_empty) begin
            grant_sumsub = (last_src_q == SRC_LDSD);
            grant_ldsd   = (last_src_q == SRC_SUMSUB);
        end else begin
            grant_sumsub = !sumsub_empty;
            grant_ldsd   = !ldsd_empty;
        end
        if (grant_sumsub) begin
            cdb_d       = pack_cdb(sumsub_head, SRC_SUMSUB);
            cdb_valid_d = 1'b1;
            last_src_d  = SRC_SUMSUB;
        end else if (grant_ldsd) begin
            cdb_d       = pack_cdb(ldsd_head, SRC_LDSD);
            cdb_valid_d = 1'b1;
            last_src_d  = SRC_LDSD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_src_q  <= SRC_LDSD;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
        end else begin
            last_src_q  <= last_src_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
        end
    end

    assign cdb       = cdb_q;
    assign cdb_valid = cdb_valid_q;

endmodule

// File: tb/tb_cdb_broadcast_unit.sv
// Scoreboard bench for cdb_broadcast_unit: a queue-level model predicts every
// broadcast word, and a monitor compares each cycle's CDB output against it.
module tb_cdb_broadcast_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        sumsub_valid, ldsd_valid;
    logic        sumsub_ready, ldsd_ready;
    logic [2:0]  sumsub_dest, ldsd_dest;
    logic [1:0]  sumsub_position, ldsd_position;
    logic [9:0]  sumsub_data, ldsd_data;
    logic [15:0] cdb;
    logic        cdb_valid;

    // Model state: entries are {dest[2:0], position[1:0], data[9:0]}
    logic [14:0] sq[$];
    logic [14:0] lq[$];
    logic [15:0] exp_q[$];
    logic        last_src;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    cdb_broadcast_unit dut (
        .clock           (clock),
        .reset           (reset),
        .sumsub_valid    (sumsub_valid),
        .sumsub_ready    (sumsub_ready),
        .sumsub_dest     (sumsub_dest),
        .sumsub_position (sumsub_position),
        .sumsub_data     (sumsub_data),
        .ldsd_valid      (ldsd_valid),
        .ldsd_ready      (ldsd_ready),
        .ldsd_dest       (ldsd_dest),
        .ldsd_position   (ldsd_position),
        .ldsd_data       (ldsd_data),
        .cdb             (cdb),
        .cdb_valid       (cdb_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model pops per the arbitration rule and
    // pushes whatever the pre-edge ready state lets in.
    task automatic drive_cycle(input logic sv, input logic [14:0] se,
                               input logic lv, input logic [14:0] le);
        logic        acc_s, acc_l;
        logic [14:0] e;
        @(negedge clock);
        chk("sumsub_ready", 32'(sumsub_ready), 32'(sq.size() < 2));
        chk("ldsd_ready", 32'(ldsd_ready), 32'(lq.size() < 2));
        sumsub_valid    = sv;
        sumsub_dest     = se[14:12];
        sumsub_position = se[11:10];
        sumsub_data     = se[9:0];
        ldsd_valid      = lv;
        ldsd_dest       = le[14:12];
        ldsd_position   = le[11:10];
        ldsd_data       = le[9:0];
        acc_s = sv && (sq.size() < 2);
        acc_l = lv && (lq.size() < 2);
        if (sq.size() > 0 && (lq.size() == 0 || last_src == 1'b0)) begin
            e = sq.pop_front();
            exp_q.push_back({e[14:10], 1'b1, e[9:0]});
            last_src = 1'b1;
        end else if (lq.size() > 0) begin
            e = lq.pop_front();
            exp_q.push_back({e[14:10], 1'b0, e[9:0]});
            last_src = 1'b0;
        end
        if (acc_s) sq.push_back(se);
        if (acc_l) lq.push_back(le);
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
    endtask

    // Monitor: one comparison per cycle, popping the scoreboard on each broadcast
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_broadcast actual=%h required=none (t=%0t)", cdb, $time);
                end else begin
                    chk("cdb_word", 32'(cdb), 32'(exp_q.pop_front()));
                end
            end else begin
                chk("cdb_idle_zero", 32'(cdb), 32'h0);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        sumsub_valid = 1'b0; sumsub_dest = '0; sumsub_position = '0; sumsub_data = '0;
        ldsd_valid   = 1'b0; ldsd_dest   = '0; ldsd_position   = '0; ldsd_data   = '0;
        last_src     = 1'b0;
        #1;
        chk("reset_cdb", 32'(cdb), 32'h0);
        chk("reset_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("reset_sumsub_ready", 32'(sumsub_ready), 32'h1);
        chk("reset_ldsd_ready", 32'(ldsd_ready), 32'h1);
        #21 reset = 1'b0;
        #1;
        chk("release_cdb", 32'(cdb), 32'h0);
        chk("release_cdb_valid", 32'(cdb_valid), 32'h0);

        // Tie right after reset: sum/sub first, load/store next
        drive_cycle(1'b1, {3'b100, 2'd0, 10'h011}, 1'b1, {3'b001, 2'd3, 10'h022});
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("tie_first_src", 32'(cdb[10]), 32'h1);
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("tie_second_src", 32'(cdb[10]), 32'h0);
        chk("tie_second_valid", 32'(cdb_valid), 32'h1);
        idle(1);

        // Single sum/sub push: nothing at edge k, word after edge k+1, then idle
        drive_cycle(1'b1, {3'b010, 2'd2, 10'h155}, 1'b0, 15'h0);
        chk("no_bypass_valid", 32'(cdb_valid), 32'h0);
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("single_sumsub_word", 32'(cdb), 32'h5555);
        chk("single_sumsub_valid", 32'(cdb_valid), 32'h1);
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("single_sumsub_after", 32'(cdb), 32'h0);

        // Store with no register write still broadcasts
        drive_cycle(1'b0, 15'h0, 1'b1, {3'b000, 2'd1, 10'h3FF});
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("store_word", 32'(cdb), 32'h0BFF);
        chk("store_valid", 32'(cdb_valid), 32'h1);
        idle(2);

        // Both sources streaming with incrementing data
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, {3'b100, 2'd0, 10'(i)}, 1'b1, {3'b001, 2'd3, 10'(100 + i)});
        end
        idle(6);

        // Randomized traffic, including non-one-hot and zero destinations
        for (int i = 0; i < 300; i++) begin
            drive_cycle($urandom_range(0, 99) < 60, 15'($urandom),
                        $urandom_range(0, 99) < 60, 15'($urandom));
        end

        // Load the FIFOs, then reset between edges
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 15'($urandom), 1'b1, 15'($urandom));
        end
        chk("busy_before_reset", 32'(cdb_valid), 32'h1);
        sumsub_valid = 1'b0;
        ldsd_valid   = 1'b0;
        reset        = 1'b1;
        #1;
        chk("async_reset_cdb", 32'(cdb), 32'h0);
        chk("async_reset_valid", 32'(cdb_valid), 32'h0);
        chk("async_reset_sumsub_ready", 32'(sumsub_ready), 32'h1);
        chk("async_reset_ldsd_ready", 32'(ldsd_ready), 32'h1);
        sq.delete();
        lq.delete();
        exp_q.delete();
        last_src = 1'b0;
        @(negedge clock);
        #1 reset = 1'b0;
        idle(3);

        // Round-robin pointer restarts in favour of sum/sub
        drive_cycle(1'b1, {3'b010, 2'd1, 10'h0AA}, 1'b1, {3'b100, 2'd2, 10'h0BB});
        drive_cycle(1'b0, 15'h0, 1'b0, 15'h0);
        chk("post_reset_tie_src", 32'(cdb[10]), 32'h1);
        idle(6);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
